ex_mem_skid_stage: RTL and testbench
====================================

Name: ex_mem_skid_stage

Overview:
Registered hand-off between the execute stage (shifter/ALU result side) and the memory stage. Captures one execute result per cycle with a valid/ready handshake. A one-entry skid register lets the execute stage see a registered ready while the memory stage back-pressures. Also exports the held result as a forwarding source for the execute operand muxes, and supports a pipeline flush.

Parameters:
size, 32, datapath width of result, store data and pc
reg_addr_w, 5, register-file address width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge
flush  input  1  synchronous kill of every held and incoming beat
in_valid  input  1  execute stage presents a result
in_ready  output  1  stage can accept; registered, equals ~skid_valid
in_result  input  size  ALU/shifter result or memory address
in_store_data  input  size  rs2 value for stores
in_pc  input  size  instruction pc
in_rd  input  reg_addr_w  destination register
in_reg_we  input  1  register write enable
in_mem_we  input  1  store
in_mem_re  input  1  load
in_funct3  input  3  memory access size/sign
out_valid  output  1  memory stage payload valid
out_ready  input  1  memory stage accepts
out_result, out_store_data, out_pc, out_rd, out_reg_we, out_mem_we, out_mem_re, out_funct3  output  (as input)  held payload
fwd_valid  output  1  out_valid & out_reg_we & ~out_mem_re
fwd_rd  output  reg_addr_w  out_rd
fwd_data  output  size  out_result

Behaviour:
- Storage: out register (out_valid + payload) and skid register (skid_valid + payload).
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = ~skid_valid, taken directly from a flop with no combinational path from out_ready.
- Reset: out_valid=0, skid_valid=0, in_ready=1, all payload outputs 0, fwd_valid=0.
- Priority: reset > flush > normal.
- Flush: next cycle out_valid=0 and skid_valid=0. A beat accepted in the flush cycle is dropped. Payload registers hold their values (don't care while invalid).
- Normal operation, evaluated per cycle:
  * out empty or drain, skid_valid=1: out <= skid; skid_valid <= 0. accept is impossible because in_ready=0.
  * out empty or drain, skid_valid=0: out <= in payload; out_valid <= accept.
  * out_valid & ~out_ready & accept: skid <= in payload; skid_valid <= 1; out holds.
  * out_valid & ~out_ready & ~accept: everything holds.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 beat/cycle while out_ready=1.
- Ordering is strictly FIFO; the skid entry always leaves before any newer beat.
- x0 rule: on capture into either register, reg_we is stored as in_reg_we & (in_rd != 0).
- Load/store sanity: if in_mem_we & in_mem_re are both 1, both are stored as 0 and reg_we is kept (treated as ALU op).
- No beat is ever duplicated or lost except through flush or reset.
- Payload of a held out register is stable while out_valid & ~out_ready.

Decomposition:
- Package ex_mem_pkg holds:
  * struct ex_mem_payload_t {result, store_data, pc, rd, reg_we, mem_we, mem_re, funct3}
  * constants REG_ADDR_W=5 and FUNCT3_W=3
  * function sanitize_payload (x0 and load/store rules)
- One natural sub-module: ex_mem_payload_reg, an enable-loaded payload register instantiated twice (out and skid).
- Handshake control stays in the top.

Test Plan:
- Reset held 2 cycles, then released with in_valid=0 -> out_valid=0, in_ready=1, fwd_valid=0, all payload 0.
- Stream A(result 0x00000010), B(0x00000020), C(0x00000030) back to back with out_ready=1 -> out shows A, B, C on cycles 1, 2, 3 after acceptance; in_ready stays 1.
- out_ready=0 after A is held, B presented -> B goes to skid, in_ready=0. With C pending, raise out_ready -> A drains, then B, then C is accepted; order A, B, C with no loss.
- in_rd=0, in_reg_we=1, result 0xDEADBEEF -> out_reg_we=0, fwd_valid=0. Load with rd=5 -> fwd_valid=0. ALU op with rd=5 -> fwd_valid=1, fwd_rd=5, fwd_data=result.
- Both registers full, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the incoming beat never appears.
- reset asserted while skid_valid=1 and out_ready=0 -> next cycle all valids 0 and payload 0. Simultaneous flush and reset -> reset values.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - shared types, widths and payload sanitiser for the EX/MEM hand-off
package ex_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int FUNCT3_W   = 3;

  // Bit 0 doubles as out_valid and bit 1 as skid_valid, so both come straight off flops
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } stage_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [DATA_W-1:0]     store_data;
    logic [DATA_W-1:0]     pc;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_we;
    logic                  mem_we;
    logic                  mem_re;
    logic [FUNCT3_W-1:0]   funct3;
  } ex_mem_payload_t;

  function automatic ex_mem_payload_t sanitize_payload(ex_mem_payload_t p);
    ex_mem_payload_t s;
    s = p;
    if (p.rd == '0) s.reg_we = 1'b0;
    // Contradictory load+store degrades to a plain ALU op
    if (p.mem_we && p.mem_re) begin
      s.mem_we = 1'b0;
      s.mem_re = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/ex_mem_skid_stage_if.sv
// rtl/ex_mem_skid_stage_if.sv - execute-side input, memory-side output and forwarding bundle
interface ex_mem_skid_stage_if #(
  parameter int size       = ex_mem_pkg::DATA_W,
  parameter int reg_addr_w = ex_mem_pkg::REG_ADDR_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [size-1:0]       in_result;
  logic [size-1:0]       in_store_data;
  logic [size-1:0]       in_pc;
  logic [reg_addr_w-1:0] in_rd;
  logic                  in_reg_we;
  logic                  in_mem_we;
  logic                  in_mem_re;
  logic [2:0]            in_funct3;

  logic                  out_valid;
  logic                  out_ready;
  logic [size-1:0]       out_result;
  logic [size-1:0]       out_store_data;
  logic [size-1:0]       out_pc;
  logic [reg_addr_w-1:0] out_rd;
  logic                  out_reg_we;
  logic                  out_mem_we;
  logic                  out_mem_re;
  logic [2:0]            out_funct3;

  logic                  fwd_valid;
  logic [reg_addr_w-1:0] fwd_rd;
  logic [size-1:0]       fwd_data;

  modport slave (
    input  in_valid, in_result, in_store_data, in_pc, in_rd, in_reg_we,
           in_mem_we, in_mem_re, in_funct3, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_pc, out_rd,
           out_reg_we, out_mem_we, out_mem_re, out_funct3,
           fwd_valid, fwd_rd, fwd_data
  );

  modport master (
    output in_valid, in_result, in_store_data, in_pc, in_rd, in_reg_we,
           in_mem_we, in_mem_re, in_funct3, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_pc, out_rd,
           out_reg_we, out_mem_we, out_mem_re, out_funct3,
           fwd_valid, fwd_rd, fwd_data
  );

endinterface

// File: rtl/ex_mem_payload_reg.sv
// rtl/ex_mem_payload_reg.sv - enable-loaded payload register, cleared by reset
module ex_mem_payload_reg
  import ex_mem_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  ex_mem_payload_t d,
  output ex_mem_payload_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - EX/MEM pipeline register with one-entry skid and forwarding tap
module ex_mem_skid_stage
  import ex_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  ex_mem_skid_stage_if.slave   bus
);

  stage_state_t    state, state_n;
  logic            accept;
  logic            out_load, skid_load, out_from_skid;
  ex_mem_payload_t in_raw, in_pay, out_d, out_q, skid_q;

  assign bus.in_ready  = ~state[1];
  assign bus.out_valid = state[0];
  assign accept        = bus.in_valid & ~state[1];

  always_comb begin
    in_raw            = '0;
    in_raw.result     = bus.in_result;
    in_raw.store_data = bus.in_store_data;
    in_raw.pc         = bus.in_pc;
    in_raw.rd         = bus.in_rd;
    in_raw.reg_we     = bus.in_reg_we;
    in_raw.mem_we     = bus.in_mem_we;
    in_raw.mem_re     = bus.in_mem_re;
    in_raw.funct3     = bus.in_funct3;
  end

  assign in_pay = sanitize_payload(in_raw);
  assign out_d  = out_from_skid ? skid_q : in_pay;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    out_load      = 1'b0;
    skid_load     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        out_load = 1'b1;
        if (accept) state_n = ST_FULL;
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          out_load = 1'b1;
          state_n  = accept ? ST_FULL : ST_EMPTY;
        end else if (accept) begin
          skid_load = 1'b1;
          state_n   = ST_SKID;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so nothing new can arrive while the skid drains
        if (bus.out_ready) begin
          out_load      = 1'b1;
          out_from_skid = 1'b1;
          state_n       = ST_FULL;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    if (flush) begin
      state_n   = ST_EMPTY;
      out_load  = 1'b0;
      skid_load = 1'b0;
    end
  end

  ex_mem_payload_reg u_out_reg (
    .clk   (clk),
    .reset (reset),
    .load  (out_load),
    .d     (out_d),
    .q     (out_q)
  );

  ex_mem_payload_reg u_skid_reg (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_pay),
    .q     (skid_q)
  );

  assign bus.out_result     = out_q.result;
  assign bus.out_store_data = out_q.store_data;
  assign bus.out_pc         = out_q.pc;
  assign bus.out_rd         = out_q.rd;
  assign bus.out_reg_we     = out_q.reg_we;
  assign bus.out_mem_we     = out_q.mem_we;
  assign bus.out_mem_re     = out_q.mem_re;
  assign bus.out_funct3     = out_q.funct3;

  assign bus.fwd_valid = state[0] & out_q.reg_we & ~out_q.mem_re;
  assign bus.fwd_rd    = out_q.rd;
  assign bus.fwd_data  = out_q.result;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb/tb_ex_mem_skid_stage.sv - directed vector bench for ex_mem_skid_stage
module tb_ex_mem_skid_stage;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  ex_mem_skid_stage_if bus ();

  ex_mem_skid_stage dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, fl, iv;
    logic [31:0] res;
    logic [4:0]  rd;
    bit          rwe, mwe, mre, ordy;
    bit          eov, eir;
    logic [31:0] eres;
    logic [4:0]  erd;
    bit          erwe, emwe, emre, efv, epay;
  } vec_t;

  int nerr   = 0;
  int nchecks = 0;

  vec_t vecs[28];

  function automatic vec_t mk(bit rst, bit fl, bit iv, logic [31:0] res, logic [4:0] rd,
                              bit rwe, bit mwe, bit mre, bit ordy,
                              bit eov, bit eir, logic [31:0] eres, logic [4:0] erd,
                              bit erwe, bit emwe, bit emre, bit efv, bit epay);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.res = res; v.rd = rd;
    v.rwe = rwe; v.mwe = mwe; v.mre = mre; v.ordy = ordy;
    v.eov = eov; v.eir = eir; v.eres = eres; v.erd = erd;
    v.erwe = erwe; v.emwe = emwe; v.emre = emre; v.efv = efv; v.epay = epay;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Store data, pc and funct3 are derived from result/rd so a zero beat is all-zero
  task automatic drive(bit iv, logic [31:0] res, logic [4:0] rd, bit rwe, bit mwe, bit mre);
    bus.in_valid      = iv;
    bus.in_result     = res;
    bus.in_store_data = {res[15:0], res[31:16]};
    bus.in_pc         = res << 2;
    bus.in_rd         = rd;
    bus.in_reg_we     = rwe;
    bus.in_mem_we     = mwe;
    bus.in_mem_re     = mre;
    bus.in_funct3     = rd[2:0];
  endtask

  logic [31:0] sb_q[$];
  logic [31:0] exp_front;
  logic [7:0]  pat;
  int          sent, got;

  initial begin
    vecs[0]  = mk(1,0,0, 32'h0,        5'd0, 0,0,0, 1,  0,1, 32'h0,        5'd0, 0,0,0,0, 1);
    vecs[1]  = mk(1,0,0, 32'h0,        5'd0, 0,0,0, 1,  0,1, 32'h0,        5'd0, 0,0,0,0, 1);
    vecs[2]  = mk(0,0,0, 32'h0,        5'd0, 0,0,0, 1,  0,1, 32'h0,        5'd0, 0,0,0,0, 1);
    vecs[3]  = mk(0,0,1, 32'h10,       5'd1, 1,0,0, 1,  1,1, 32'h10,       5'd1, 1,0,0,1, 1);
    vecs[4]  = mk(0,0,1, 32'h20,       5'd2, 1,0,0, 1,  1,1, 32'h20,       5'd2, 1,0,0,1, 1);
    vecs[5]  = mk(0,0,1, 32'h30,       5'd3, 1,0,0, 1,  1,1, 32'h30,       5'd3, 1,0,0,1, 1);
    vecs[6]  = mk(0,0,0, 32'h0,        5'd0, 0,0,0, 1,  0,1, 32'h0,        5'd0, 0,0,0,0, 0);
    vecs[7]  = mk(0,0,1, 32'h11,       5'd4, 1,0,0, 0,  1,1, 32'h11,       5'd4, 1,0,0,1, 1);
    vecs[8]  = mk(0,0,1, 32'h21,       5'd5, 1,0,0, 0,  1,0, 32'h11,       5'd4, 1,0,0,1, 1);
    vecs[9]  = mk(0,0,1, 32'h31,       5'd6, 1,0,0, 0,  1,0, 32'h11,       5'd4, 1,0,0,1, 1);
    vecs[10] = mk(0,0,1, 32'h31,       5'd6, 1,0,0, 1,  1,1, 32'h21,       5'd5, 1,0,0,1, 1);
    vecs[11] = mk(0,0,1, 32'h31,       5'd6, 1,0,0, 1,  1,1, 32'h31,       5'd6, 1,0,0,1, 1);
    vecs[12] = mk(0,0,0, 32'h0,        5'd0, 0,0,0, 1,  0,1, 32'h0,        5'd0, 0,0,0,0, 0);
    vecs[13] = mk(0,0,1, 32'hDEADBEEF, 5'd0, 1,0,0, 1,  1,1, 32'hDEADBEEF, 5'd0, 0,0,0,0, 1);
    vecs[14] = mk(0,0,1, 32'h100,      5'd5, 1,0,1, 1,  1,1, 32'h100,      5'd5, 1,0,1,0, 1);
    vecs[15] = mk(0,0,1, 32'h200,      5'd5, 1,1,1, 1,  1,1, 32'h200,      5'd5, 1,0,0,1, 1);
    vecs[16] = mk(0,0,1, 32'h300,      5'd5, 1,0,0, 1,  1,1, 32'h300,      5'd5, 1,0,0,1, 1);
    vecs[17] = mk(0,0,0, 32'h0,        5'd0, 0,0,0, 1,  0,1, 32'h0,        5'd0, 0,0,0,0, 0);
    vecs[18] = mk(0,0,1, 32'h40,       5'd7, 1,0,0, 0,  1,1, 32'h40,       5'd7, 1,0,0,1, 1);
    vecs[19] = mk(0,0,1, 32'h50,       5'd8, 1,0,0, 0,  1,0, 32'h40,       5'd7, 1,0,0,1, 1);
    vecs[20] = mk(0,1,1, 32'h60,       5'd9, 1,0,0, 0,  0,1, 32'h0,        5'd0, 0,0,0,0, 0);
    vecs[21] = mk(0,0,0, 32'h0,        5'd0, 0,0,0, 1,  0,1, 32'h0,        5'd0, 0,0,0,0, 0);
    vecs[22] = mk(0,0,1, 32'h70,       5'd9, 1,0,0, 0,  1,1, 32'h70,       5'd9, 1,0,0,1, 1);
    vecs[23] = mk(0,0,1, 32'h80,       5'd10,1,0,0, 0,  1,0, 32'h70,       5'd9, 1,0,0,1, 1);
    vecs[24] = mk(1,0,1, 32'h80,       5'd10,1,0,0, 0,  0,1, 32'h0,        5'd0, 0,0,0,0, 1);
    vecs[25] = mk(0,0,1, 32'h90,       5'd11,1,0,0, 0,  1,1, 32'h90,       5'd11,1,0,0,1, 1);
    vecs[26] = mk(1,1,1, 32'hA0,       5'd12,1,0,0, 0,  0,1, 32'h0,        5'd0, 0,0,0,0, 1);
    vecs[27] = mk(0,0,0, 32'h0,        5'd0, 0,0,0, 0,  0,1, 32'h0,        5'd0, 0,0,0,0, 1);

    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, 32'h0, 5'd0, 0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      flush = vecs[i].fl;
      bus.out_ready = vecs[i].ordy;
      drive(vecs[i].iv, vecs[i].res, vecs[i].rd, vecs[i].rwe, vecs[i].mwe, vecs[i].mre);
      @(posedge clk);
      #1;
      chk("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].eov));
      chk("in_ready",  i, 32'(bus.in_ready),  32'(vecs[i].eir));
      chk("fwd_valid", i, 32'(bus.fwd_valid), 32'(vecs[i].efv));
      if (vecs[i].epay) begin
        chk("out_result",     i, bus.out_result, vecs[i].eres);
        chk("out_store_data", i, bus.out_store_data, {vecs[i].eres[15:0], vecs[i].eres[31:16]});
        chk("out_pc",         i, bus.out_pc, vecs[i].eres << 2);
        chk("out_rd",         i, 32'(bus.out_rd), 32'(vecs[i].erd));
        chk("out_funct3",     i, 32'(bus.out_funct3), 32'(vecs[i].erd[2:0]));
        chk("out_reg_we",     i, 32'(bus.out_reg_we), 32'(vecs[i].erwe));
        chk("out_mem_we",     i, 32'(bus.out_mem_we), 32'(vecs[i].emwe));
        chk("out_mem_re",     i, 32'(bus.out_mem_re), 32'(vecs[i].emre));
        chk("fwd_rd",         i, 32'(bus.fwd_rd), 32'(vecs[i].erd));
        chk("fwd_data",       i, bus.fwd_data, vecs[i].eres);
      end
    end

    // Irregular back-pressure stream: every accepted beat must drain once, in order
    pat  = 8'b1011_0010;
    sent = 0;
    got  = 0;
    reset = 1'b0;
    flush = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      drive(sent < 10, 32'h1000 + 32'(sent), 5'(sent + 1), 1, 0, 0);
      bus.out_ready = (cyc < 30) ? pat[cyc % 8] : 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("stream_spurious", cyc, bus.out_result, 32'hFFFF_FFFF);
        end else begin
          exp_front = sb_q.pop_front();
          chk("stream_order", cyc, bus.out_result, exp_front);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(bus.in_result);
        sent++;
      end
      @(posedge clk);
    end
    chk("stream_sent",    0, 32'(sent), 32'd10);
    chk("stream_drained", 0, 32'(got), 32'd10);
    chk("stream_left",    0, 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
